// File: rtl/spike_event_logger.sv
// rtl/spike_event_logger.sv - timestamped spike event FIFO with sticky overflow
module spike_event_logger #(
    parameter int TS_WIDTH = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  spike,
    input  logic [3:0]            state,
    input  logic                  clear_ovf,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [TS_WIDTH+3:0]   out_data,
    output logic [ADDR_W:0]       count,
    output logic                  overflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [TS_WIDTH-1:0] ts;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     cnt;
    logic                ovf;
    logic [TS_WIDTH+3:0] mem [DEPTH];

    logic push_req;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;

    always_comb begin
        push_req = spike & enable;
        full     = (cnt == FULL_CNT);
        pop      = out_valid & out_ready;
        // A full FIFO still accepts a push when the head leaves on the same edge
        push_ok  = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts     <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (enable)
                ts <= ts + TS_WIDTH'(1);
            if (push_ok)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + (ADDR_W+1)'(1);
                2'b01:   cnt <= cnt - (ADDR_W+1)'(1);
                default: cnt <= cnt;
            endcase
            if (drop)
                ovf <= 1'b1;
            else if (clear_ovf)
                ovf <= 1'b0;
        end
    end

    // Storage carries no reset; stale entries are masked by the occupancy count
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= {ts, state};
    end

    always_comb begin
        out_valid = (cnt != '0);
        out_data  = out_valid ? mem[rd_ptr] : '0;
        count     = cnt;
        overflow  = ovf;
    end

endmodule

// File: tb/tb_spike_event_logger.sv
// tb/tb_spike_event_logger.sv - directed and random checks against a queue model
module tb_spike_event_logger;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        spike;
    logic [3:0]  state;
    logic        clear_ovf;
    logic        out_ready;
    logic        out_valid;
    logic [11:0] out_data;
    logic [3:0]  count;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  m_ts;
    logic        m_ovf;
    logic [11:0] m_q[$];
    logic [7:0]  held_ts;

    always #5 clk = ~clk;

    spike_event_logger #(.TS_WIDTH(8), .DEPTH(8), .ADDR_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .spike     (spike),
        .state     (state),
        .clear_ovf (clear_ovf),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ts  = '0;
        m_ovf = 1'b0;
        m_q.delete();
    endtask

    task automatic chk_model();
        chk("valid", 32'(out_valid), 32'(m_q.size() != 0));
        chk("count", 32'(count), 32'(m_q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (m_q.size() != 0)
            chk("data", 32'(out_data), 32'(m_q[0]));
    endtask

    // Drive one cycle just after an edge, advance the model at the next edge, then check
    task automatic cycle(input logic en, input logic sp, input logic [3:0] st,
                         input logic clr, input logic rdy);
        logic        did_pop;
        logic        drop;
        logic [11:0] ev;
        enable    = en;
        spike     = sp;
        state     = st;
        clear_ovf = clr;
        out_ready = rdy;
        ev        = {m_ts, st};
        @(posedge clk);
        did_pop = rdy && (m_q.size() != 0);
        drop    = 1'b0;
        if (did_pop)
            void'(m_q.pop_front());
        if (en && sp) begin
            if (m_q.size() < DEPTH)
                m_q.push_back(ev);
            else
                drop = 1'b1;
        end
        m_ovf = drop | (m_ovf & ~clr);
        if (en)
            m_ts = m_ts + 8'd1;
        #1;
        chk_model();
    endtask

    task automatic idle_to_ts(input logic [7:0] target);
        while (m_ts != target)
            cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && m_q.size() != 0; i++)
            cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; spike = 1'b0; state = 4'd0;
        clear_ovf = 1'b0; out_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        reset = 1'b0;
        cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Single event at TS=5
        idle_to_ts(8'd5);
        cycle(1'b1, 1'b1, 4'd9, 1'b0, 1'b0);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'h059);
        chk("single_count", 32'(count), 32'd1);
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        chk("single_pop_count", 32'(count), 32'd0);
        chk("single_pop_valid", 32'(out_valid), 32'd0);

        // Consecutive-cycle spikes
        idle_to_ts(8'd10);
        cycle(1'b1, 1'b1, 4'd8, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'd10, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'd12, 1'b0, 1'b0);
        chk("burst_count", 32'(count), 32'd3);
        chk("burst_head0", 32'(out_data), 32'h0A8);
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        chk("burst_head1", 32'(out_data), 32'h0BA);
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        chk("burst_head2", 32'(out_data), 32'h0CC);
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);

        // Overflow: nine spikes into eight entries
        for (int i = 0; i < 9; i++)
            cycle(1'b1, 1'b1, 4'(i), 1'b0, 1'b0);
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        drain();
        cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Full with simultaneous pop and push
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 1'b1, 4'(i + 3), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'd15, 1'b0, 1'b1);
        chk("fullpp_count", 32'(count), 32'd8);
        chk("fullpp_ovf", 32'(overflow), 32'd0);
        chk("fullpp_tail", 32'(m_q[7]), 32'({m_ts - 8'd1, 4'd15}));
        drain();

        // Drop and clear on the same edge: set wins
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'd2, 1'b1, 1'b0);
        chk("setwins_ovf", 32'(overflow), 32'd1);
        drain();
        cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);

        // Disabled: spikes ignored, timestamp holds
        held_ts = m_ts;
        for (int i = 0; i < 20; i++)
            cycle(1'b0, 1'b1, 4'd6, 1'b0, 1'b1);
        chk("dis_count", 32'(count), 32'd0);
        cycle(1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
        chk("dis_resume", 32'(out_data), 32'({held_ts, 4'd3}));
        drain();

        // Timestamp wrap
        idle_to_ts(8'd255);
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'd7, 1'b0, 1'b0);
        chk("wrap_data", 32'(out_data), 32'h007);
        drain();

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            cycle(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                  4'($urandom), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 9) < 4));
        drain();

        // Asynchronous reset between edges with four entries and overflow set
        for (int i = 0; i < 9; i++)
            cycle(1'b1, 1'b1, 4'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        chk("pre_rst_count", 32'(count), 32'd4);
        spike = 1'b0; out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        model_reset();
        #2;
        reset = 1'b0;
        cycle(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
        chk("post_rst_data", 32'(out_data), 32'h005);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
